mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between an instruction-fetch port (if_*)
// and a data port (dm_*). Only one access is in flight at a time: a
// request is granted combinationally while the arbiter is idle. The access
// is then issued to memory on the following cycle. The read data is
// captured once the memory latency has elapsed, and it is returned to the
// requester with a one-cycle rvalid pulse.
//
// Parameters
//   MEM_LAT     memory read latency in cycles after the mem_en cycle (1..15)
//   STARVE_MAX  consecutive data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   if_req/if_addr              fetch request and byte address
//   if_gnt/if_rvalid/if_rdata   fetch accept, data valid pulse, instruction
//   dm_req/dm_we/dm_addr/
//   dm_wdata                    data request, store flag, address, store data
//   dm_gnt/dm_rvalid/dm_rdata   data accept, done pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         single-port memory interface
//
// Build option
//   ARB_STARVE_GUARD_EN  when defined, fetch wins a contended cycle after
//                        STARVE_MAX data grants in a row while fetch waited.
//                        When undefined, the data port always has priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [63:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
    end

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;

    localparam logic [3:0] LP_MEM_LAT = 4'(MEM_LAT);

    logic [1:0]  r_state;
    logic [3:0]  r_lat_cnt;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_dm_rvalid;
    logic [63:0] r_dm_rdata;

    logic        w_idle;
    logic        w_if_win;
    logic        w_dm_win;
    logic        w_done;
    logic        w_if_first;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    // Fetch takes priority only once the data port has used up its run.
    assign w_if_first = (r_starve_cnt == LP_STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_if_win) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dm_win && if_req) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    assign w_if_first = 1'b0;
`endif

    // Grant decision: combinational, only while idle.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_if_win = 1'b0;
        w_dm_win = 1'b0;
        if (w_idle) begin
            if (if_req && (!dm_req || w_if_first)) begin
                w_if_win = 1'b1;
            end else if (dm_req) begin
                w_dm_win = 1'b1;
            end
        end
    end

    // The counter starts at 0 in the mem_en cycle, so it reaches MEM_LAT
    // exactly in the cycle where mem_rdata is valid.
    assign w_done = (r_lat_cnt == LP_MEM_LAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= 4'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= 64'd0;
        end else begin
            r_mem_en    <= w_if_win | w_dm_win;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (w_if_win) begin
                r_state     <= S_BUSY_IF;
                r_lat_cnt   <= 4'd0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= 64'd0;
            end else if (w_dm_win) begin
                r_state     <= S_BUSY_DM;
                r_lat_cnt   <= 4'd0;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (r_state == S_BUSY_IF || r_state == S_BUSY_DM) begin
                if (w_done) begin
                    r_state   <= S_IDLE;
                    r_lat_cnt <= 4'd0;
                    if (r_state == S_BUSY_IF) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= mem_rdata[31:0];
                    end else begin
                        r_dm_rvalid <= 1'b1;
                        // Stores complete without disturbing the load data.
                        if (!r_mem_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end else begin
                    r_lat_cnt <= r_lat_cnt + 4'd1;
                end
            end else if (r_state != S_IDLE) begin
                // Unused encoding: recover to idle.
                r_state   <= S_IDLE;
                r_lat_cnt <= 4'd0;
            end
        end
    end

    // Grants are combinational, so they are masked while reset is asserted.
    assign if_gnt    = w_if_win & ~reset;
    assign dm_gnt    = w_dm_win & ~reset;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a latency-accurate memory model.
// Requester tasks push the expected memory access and the expected response
// when they see their grant. Independent monitors pop those expectations
// whenever the DUT drives mem_en or an rvalid pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int GNT_TMO    = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [63:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_dm;
        logic [63:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          cyc;
    } acc_t;

    rsp_t  sb_q[$];
    acc_t  acc_q[$];
    string gnt_log;
    logic [63:0] exp_dm_last = 64'd0;
    int n_vec = 0;
    int n_err = 0;

    // Memory contents: fixed pattern plus whatever has been written.
    logic [63:0] mem_wr_data [128];
    bit          mem_wr_vld  [128];
    logic [63:0] exp_data    [128];
    bit          exp_vld     [128];
    logic [63:0] rd_pipe     [MEM_LAT];

    function automatic int widx(input logic [63:0] a);
        return int'(a[9:3]);
    endfunction

    function automatic logic [63:0] base_word(input int i);
        if (i == 2) return 64'hCAFE_F00D_0050_0093;
        return {32'hC0DE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i) * 32'h11};
    endfunction

    function automatic logic [63:0] mem_word(input int i);
        return mem_wr_vld[i] ? mem_wr_data[i] : base_word(i);
    endfunction

    function automatic logic [63:0] exp_word(input int i);
        return exp_vld[i] ? exp_data[i] : base_word(i);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_wr_data[widx(mem_addr)] <= mem_wdata;
            mem_wr_vld[widx(mem_addr)]  <= 1'b1;
        end
        rd_pipe[0] <= mem_en ? mem_word(widx(mem_addr)) : 64'hDEAD_BEEF_BAD0_BAD0;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm, input string detail);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", nm, detail);
    endfunction

    function automatic void check_zero(input string tag);
        chk({tag, "_if_gnt"},    64'(if_gnt),    64'd0);
        chk({tag, "_dm_gnt"},    64'(dm_gnt),    64'd0);
        chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd0);
        chk({tag, "_dm_rvalid"}, 64'(dm_rvalid), 64'd0);
        chk({tag, "_mem_en"},    64'(mem_en),    64'd0);
        chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
        chk({tag, "_mem_addr"},  mem_addr,       64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      64'd0);
        chk({tag, "_if_rdata"},  64'(if_rdata),  64'd0);
        chk({tag, "_dm_rdata"},  dm_rdata,       64'd0);
    endfunction

    // Response and memory-access monitor.
    always @(negedge clk) begin : mon
        rsp_t r;
        acc_t a;
        if (!reset) begin
            if (if_gnt && dm_gnt) fail("double_gnt", "if_gnt and dm_gnt both high");
            if (if_rvalid && dm_rvalid) fail("double_rvalid", "if_rvalid and dm_rvalid both high");
            if (if_rvalid || dm_rvalid) begin
                if (sb_q.size() == 0) begin
                    fail("unexpected_rvalid", $sformatf("if_rvalid=%0b dm_rvalid=%0b at cycle %0d with nothing outstanding",
                         if_rvalid, dm_rvalid, cyc));
                end else begin
                    r = sb_q.pop_front();
                    chk("rvalid_port_is_dm", 64'(dm_rvalid), 64'(r.is_dm));
                    chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    if (r.is_dm) chk("dm_rdata", dm_rdata, r.data);
                    else         chk("if_rdata", 64'(if_rdata), r.data);
                end
            end
            if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
                r = sb_q.pop_front();
                fail("missing_rvalid", $sformatf("no rvalid at cycle %0d, expected one there", r.cyc));
            end
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    fail("unexpected_mem_en", $sformatf("mem_en high at cycle %0d with no grant", cyc));
                end else begin
                    a = acc_q.pop_front();
                    chk("mem_en_cycle", 64'(cyc), 64'(a.cyc));
                    chk("mem_we",       64'(mem_we), 64'(a.we));
                    chk("mem_addr",     mem_addr, a.addr);
                    chk("mem_wdata",    mem_wdata, a.wdata);
                end
            end
            if (acc_q.size() > 0 && cyc > acc_q[0].cyc) begin
                a = acc_q.pop_front();
                fail("missing_mem_en", $sformatf("no mem_en at cycle %0d, expected one there", a.cyc));
            end
        end
    end

    // Called just after a falling edge; returns at the falling edge after the grant.
    task automatic do_fetch(input logic [63:0] addr, input int exp_off);
        int c0;
        int n;
        rsp_t r;
        acc_t a;
        c0 = cyc;
        n = 0;
        if_req  = 1'b1;
        if_addr = addr;
        #1;
        while (!if_gnt && n < GNT_TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!if_gnt) begin
            fail("if_gnt_timeout", $sformatf("no if_gnt within %0d cycles for addr 0x%0h", GNT_TMO, addr));
            if_req = 1'b0;
            return;
        end
        gnt_log = {gnt_log, "I"};
        if (exp_off >= 0) chk("if_gnt_cycle", 64'(cyc - c0), 64'(exp_off));
        r.is_dm = 1'b0;
        r.data  = {32'd0, exp_word(widx(addr))[31:0]};
        r.cyc   = cyc + MEM_LAT + 2;
        sb_q.push_back(r);
        a.we    = 1'b0;
        a.addr  = addr;
        a.wdata = 64'd0;
        a.cyc   = cyc + 1;
        acc_q.push_back(a);
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input int exp_off);
        int c0;
        int n;
        rsp_t r;
        acc_t a;
        c0 = cyc;
        n = 0;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        #1;
        while (!dm_gnt && n < GNT_TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!dm_gnt) begin
            fail("dm_gnt_timeout", $sformatf("no dm_gnt within %0d cycles for addr 0x%0h", GNT_TMO, addr));
            dm_req = 1'b0;
            return;
        end
        gnt_log = {gnt_log, "D"};
        if (exp_off >= 0) chk("dm_gnt_cycle", 64'(cyc - c0), 64'(exp_off));
        if (we) begin
            exp_data[widx(addr)] = wdata;
            exp_vld[widx(addr)]  = 1'b1;
        end else begin
            exp_dm_last = exp_word(widx(addr));
        end
        r.is_dm = 1'b1;
        r.data  = exp_dm_last;
        r.cyc   = cyc + MEM_LAT + 2;
        sb_q.push_back(r);
        a.we    = we;
        a.addr  = addr;
        a.wdata = we ? wdata : 64'd0;
        a.cyc   = cyc + 1;
        acc_q.push_back(a);
        @(negedge clk);
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    // From the falling edge after a grant to the first idle cycle.
    task automatic wait_idle();
        repeat (MEM_LAT + 1) @(negedge clk);
    endtask

    initial begin : stim
        string exp_log;
        reset    = 1'b1;
        if_req   = 1'b1;
        if_addr  = 64'h10;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 64'd0;
        dm_wdata = 64'd0;
        gnt_log  = "";
        repeat (3) @(negedge clk);
        check_zero("reset");
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch returning the addi instruction.
        do_fetch(64'h10, 0);
        wait_idle();

        // Load, then store, then load back the stored word.
        do_dm(1'b0, 64'h18, 64'd0, 0);
        wait_idle();
        do_dm(1'b1, 64'h80, 64'hDEAD, 0);
        wait_idle();
        do_dm(1'b0, 64'h80, 64'd0, 0);
        wait_idle();

        // Contention: data wins now, fetch one turnaround later.
        fork
            do_fetch(64'h20, MEM_LAT + 2);
            do_dm(1'b0, 64'h28, 64'd0, 0);
        join
        wait_idle();

        // Back-to-back fetches at the minimum turnaround.
        do_fetch(64'h30, 0);
        do_fetch(64'h38, MEM_LAT + 1);
        wait_idle();

        // Both ports requesting continuously.
        gnt_log = "";
        fork
            for (int k = 0; k < 8; k++) do_dm(1'b0, 64'h100 + 64'(k * 8), 64'd0, -1);
            for (int j = 0; j < 2; j++) do_fetch(64'h200 + 64'(j * 8), -1);
        join
`ifdef ARB_STARVE_GUARD_EN
        exp_log = "DDDDIDDDDI";
`else
        exp_log = "DDDDDDDDII";
`endif
        n_vec++;
        if (gnt_log != exp_log) begin
            n_err++;
            $display("FAIL grant_order: got %s, expected %s", gnt_log, exp_log);
        end
        wait_idle();

        // Reset two cycles into a fetch abandons it.
        do_fetch(64'h40, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        sb_q.delete();
        acc_q.delete();
        exp_dm_last = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Normal operation after reset.
        do_fetch(64'h48, 0);
        wait_idle();
        do_dm(1'b0, 64'h50, 64'd0, 0);
        wait_idle();

        repeat (MEM_LAT + 4) @(negedge clk);
        chk("sb_drained",  64'(sb_q.size()),  64'd0);
        chk("acc_drained", 64'(acc_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
